// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the radix-2 butterfly datapath.
//   DATA_W  component width (signed Q1.(DATA_W-1))
//   FRAC_W  fractional bits, i.e. the product rescale shift
//   cplx_t  packed complex sample {re, im}
//   MAX_Q / MIN_Q  saturation limits of a DATA_W component
package fft_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 15;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  localparam logic signed [DATA_W-1:0] MAX_Q = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_Q = {1'b1, {(DATA_W-1){1'b0}}};
endpackage

// File: rtl/fft_butterfly_if.sv
// fft_butterfly_if: valid/ready bus of the butterfly.
//   input side : in_valid, in_ready, a/b/w operands
//   output side: out_valid, out_ready, x0/x1 results
//   status     : ovf_clear, ovf_flag
// master = source/sink side (stage memory), slave = butterfly.
interface fft_butterfly_if;
  import fft_pkg::*;

  logic                     in_valid, in_ready;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic                     out_valid, out_ready;
  logic signed [DATA_W-1:0] x0_re, x0_im, x1_re, x1_im;
  logic                     ovf_clear, ovf_flag;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, w_re, w_im, out_ready, ovf_clear,
    input  in_ready, out_valid, x0_re, x0_im, x1_re, x1_im, ovf_flag
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, w_re, w_im, out_ready, ovf_clear,
    output in_ready, out_valid, x0_re, x0_im, x1_re, x1_im, ovf_flag
  );
endinterface

// File: rtl/fft_cmul.sv
// fft_cmul: two-stage complex multiply t = b*w, rescaled by FRAC_W.
//   clk, n_rst  clock, synchronous active-low reset
//   en_i        global pipeline enable (low = hold)
//   b_i, w_i    operand and twiddle
//   t_re_o/t_im_o  product at DATA_W+2 bits, range [-2, +2)
// Macro FFT_BUTTERFLY_ROUND_EN: round-half-up instead of floor at the shift.
module fft_cmul
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     en_i,
  input  cplx_t                    b_i,
  input  cplx_t                    w_i,
  output logic signed [DATA_W+1:0] t_re_o,
  output logic signed [DATA_W+1:0] t_im_o
);
  localparam int PW = 2*DATA_W;
`ifdef FFT_BUTTERFLY_ROUND_EN
  localparam logic signed [PW:0] RND = (PW+1)'(2 ** (FRAC_W-1));
`else
  localparam logic signed [PW:0] RND = '0;
`endif

  logic signed [PW-1:0]     prr_q, pii_q, pri_q, pir_q;
  logic signed [PW:0]       sum_re, sum_im;
  logic signed [DATA_W+1:0] t_re_q, t_im_q;

  // One extra bit so prr - pii cannot wrap (-2^15 * -2^15 case).
  assign sum_re = (PW+1)'(prr_q) - (PW+1)'(pii_q) + RND;
  assign sum_im = (PW+1)'(pri_q) + (PW+1)'(pir_q) + RND;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      prr_q  <= '0;
      pii_q  <= '0;
      pri_q  <= '0;
      pir_q  <= '0;
      t_re_q <= '0;
      t_im_q <= '0;
    end else if (en_i) begin
      prr_q  <= PW'($signed(b_i.re)) * PW'($signed(w_i.re));
      pii_q  <= PW'($signed(b_i.im)) * PW'($signed(w_i.im));
      pri_q  <= PW'($signed(b_i.re)) * PW'($signed(w_i.im));
      pir_q  <= PW'($signed(b_i.im)) * PW'($signed(w_i.re));
      t_re_q <= (DATA_W+2)'(sum_re >>> FRAC_W);
      t_im_q <= (DATA_W+2)'(sum_im >>> FRAC_W);
    end
  end

  assign t_re_o = t_re_q;
  assign t_im_o = t_im_q;
endmodule

// File: rtl/fft_butterfly.sv
// fft_butterfly: pipelined radix-2 DIT butterfly, 3-cycle latency.
//   x0 = (a + b*w)/2, x1 = (a - b*w)/2, saturated to Q1.15.
//   clk    system clock
//   n_rst  synchronous active-low reset
//   bus    fft_butterfly_if.slave (valid/ready in and out, ovf status)
// Whole pipeline stalls when the output is valid but not accepted.
// Macro FFT_BUTTERFLY_ROUND_EN: round-half-up at both shifts.
module fft_butterfly
  import fft_pkg::*;
(
  input  logic           clk,
  input  logic           n_rst,
  fft_butterfly_if.slave bus
);
  localparam int STAGES = 3;
  localparam int TW     = DATA_W + 2;
  localparam int SW     = DATA_W + 3;
`ifdef FFT_BUTTERFLY_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'(1);
`else
  localparam logic signed [SW-1:0] RND = '0;
`endif

  // Halve, then clamp; MSB of the result flags saturation.
  function automatic logic [DATA_W:0] sat_shr1(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] h;
    h = s >>> 1;
    if (h > SW'(MAX_Q))      return {1'b1, MAX_Q};
    else if (h < SW'(MIN_Q)) return {1'b1, MIN_Q};
    else                     return {1'b0, h[DATA_W-1:0]};
  endfunction

  logic [STAGES:1]          vld_pipe_q;
  logic                     stall, en;
  cplx_t                    a1_q, a2_q;
  logic signed [TW-1:0]     t_re, t_im;
  logic signed [SW-1:0]     s0_re, s0_im, s1_re, s1_im;
  logic [DATA_W:0]          r0_re, r0_im, r1_re, r1_im;
  logic                     any_sat;
  logic signed [DATA_W-1:0] x0_re_q, x0_im_q, x1_re_q, x1_im_q;
  logic                     ovf_q;

  assign stall        = vld_pipe_q[STAGES] & ~bus.out_ready;
  assign en           = ~stall;
  assign bus.in_ready = en;

  fft_cmul u_cmul (
    .clk    (clk),
    .n_rst  (n_rst),
    .en_i   (en),
    .b_i    (cplx_t'({bus.b_re, bus.b_im})),
    .w_i    (cplx_t'({bus.w_re, bus.w_im})),
    .t_re_o (t_re),
    .t_im_o (t_im)
  );

  // S3: a +/- t needs DATA_W+3 bits (|a| < 1, |t| <= 2).
  assign s0_re = SW'($signed(a2_q.re)) + SW'(t_re) + RND;
  assign s0_im = SW'($signed(a2_q.im)) + SW'(t_im) + RND;
  assign s1_re = SW'($signed(a2_q.re)) - SW'(t_re) + RND;
  assign s1_im = SW'($signed(a2_q.im)) - SW'(t_im) + RND;

  assign r0_re   = sat_shr1(s0_re);
  assign r0_im   = sat_shr1(s0_im);
  assign r1_re   = sat_shr1(s1_re);
  assign r1_im   = sat_shr1(s1_im);
  assign any_sat = r0_re[DATA_W] | r0_im[DATA_W] | r1_re[DATA_W] | r1_im[DATA_W];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      vld_pipe_q <= '0;
      a1_q       <= '0;
      a2_q       <= '0;
      x0_re_q    <= '0;
      x0_im_q    <= '0;
      x1_re_q    <= '0;
      x1_im_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (en) begin
        vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.in_valid};
        a1_q       <= cplx_t'({bus.a_re, bus.a_im});
        a2_q       <= a1_q;
        x0_re_q    <= r0_re[DATA_W-1:0];
        x0_im_q    <= r0_im[DATA_W-1:0];
        x1_re_q    <= r1_re[DATA_W-1:0];
        x1_im_q    <= r1_im[DATA_W-1:0];
      end
      // Clear beats a same-cycle set.
      if (bus.ovf_clear)
        ovf_q <= 1'b0;
      else if (en && vld_pipe_q[STAGES-1] && any_sat)
        ovf_q <= 1'b1;
    end
  end

  assign bus.out_valid = vld_pipe_q[STAGES];
  assign bus.x0_re     = x0_re_q;
  assign bus.x0_im     = x0_im_q;
  assign bus.x1_re     = x1_re_q;
  assign bus.x1_im     = x1_im_q;
  assign bus.ovf_flag  = ovf_q;
endmodule
